// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised operand stack.
// Holds the default geometry, the count-width helper and the enum naming the
// operation resolved each cycle (used by the top-level decode and the bench).
package stack_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 32;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // OP_ERR: request that only raises a sticky flag (push on full, pop/tos on empty).
    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_TOS,
        OP_REPL,
        OP_ERR
    } op_e;

endpackage

// File: rtl/stack_regfile.sv
// Storage array for param_stack: DEPTH x WIDTH registers, no reset.
// Ports:
//   clk      rising-edge clock
//   we       write enable
//   wr_addr  write index
//   wr_data  write data
//   rd_addr  combinational read index
//   rd_data  combinational read data (zero for an index beyond DEPTH-1)
module stack_regfile #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // With a non power-of-two depth the read index derived from an empty
    // count can point past the array; return zero instead of X.
    assign rd_data = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO operand stack.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   d_in                 data to push
//   push, pop, tos       requests; tos is ignored when push or pop is high
//   err_clr              clears the sticky overflow/underflow flags
//   d_out, d_valid       registered read data and its one-cycle valid pulse
//   full, empty, count   occupancy, derived from the registered count
//   overflow, underflow  sticky error flags
module param_stack
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned CW   = count_width(DEPTH),
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             err_clr,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             d_valid_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             set_ovf, set_unf;
    logic             we;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [WIDTH-1:0] rd_data;
    op_e              op;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Top entry index; only meaningful while count > 0.
    assign rd_addr = AW'(count_q - CW'(1));

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (d_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Resolve the requests into a single operation plus error side effects.
    always_comb begin
        op      = OP_IDLE;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (push && pop) begin
            if (!empty) begin
                op = OP_REPL;
            end else begin
                // Replace on an empty stack degrades to a plain push.
                op      = OP_PUSH;
                set_unf = 1'b1;
            end
        end else if (push) begin
            if (!full) begin
                op = OP_PUSH;
            end else begin
                op      = OP_ERR;
                set_ovf = 1'b1;
            end
        end else if (pop || tos) begin
            if (!empty) begin
                op = pop ? OP_POP : OP_TOS;
            end else begin
                op      = OP_ERR;
                set_unf = 1'b1;
            end
        end
    end

    always_comb begin
        count_d   = count_q;
        d_out_d   = d_out_q;
        d_valid_d = 1'b0;
        we        = 1'b0;
        wr_addr   = AW'(count_q);
        // A new error wins over a simultaneous clear.
        ovf_d     = set_ovf | (ovf_q & ~err_clr);
        unf_d     = set_unf | (unf_q & ~err_clr);
        unique case (op)
            OP_PUSH: begin
                we      = 1'b1;
                count_d = count_q + CW'(1);
            end
            OP_REPL: begin
                we        = 1'b1;
                wr_addr   = rd_addr;
                d_out_d   = rd_data;
                d_valid_d = 1'b1;
            end
            OP_POP: begin
                count_d   = count_q - CW'(1);
                d_out_d   = rd_data;
                d_valid_d = 1'b1;
            end
            OP_TOS: begin
                d_out_d   = rd_data;
                d_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            d_out_q <= '0;
            d_valid <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            d_out_q <= d_out_d;
            d_valid <= d_valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count     = count_q;
    assign d_out     = d_out_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] d_in = '0;
    logic             push = 1'b0, pop = 1'b0, tos = 1'b0, err_clr = 1'b0;
    logic [WIDTH-1:0] d_out;
    logic             d_valid, full, empty, overflow, underflow;
    logic [CW-1:0]    count;

    param_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_in      (d_in),
        .push      (push),
        .pop       (pop),
        .tos       (tos),
        .err_clr   (err_clr),
        .d_out     (d_out),
        .d_valid   (d_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue is the stack, back is the top.
    logic [WIDTH-1:0] stk [$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_valid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic o, input logic t, input logic c,
                              input logic [WIDTH-1:0] d);
        int  n;
        logic e_ovf, e_unf;
        n       = stk.size();
        e_ovf   = 1'b0;
        e_unf   = 1'b0;
        m_valid = 1'b0;
        if (p && o) begin
            if (n > 0) begin
                m_dout     = stk[n-1];
                stk[n-1]   = d;
                m_valid    = 1'b1;
            end else begin
                stk.push_back(d);
                e_unf = 1'b1;
            end
        end else if (p) begin
            if (n < DEPTH) stk.push_back(d);
            else e_ovf = 1'b1;
        end else if (o) begin
            if (n > 0) begin
                m_dout  = stk.pop_back();
                m_valid = 1'b1;
            end else e_unf = 1'b1;
        end else if (t) begin
            if (n > 0) begin
                m_dout  = stk[n-1];
                m_valid = 1'b1;
            end else e_unf = 1'b1;
        end
        m_ovf = e_ovf ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = e_unf ? 1'b1 : (c ? 1'b0 : m_unf);
    endtask

    // Drive on the falling edge, update the model at the rising edge.
    task automatic step(input logic p, input logic o, input logic t, input logic c,
                        input logic [WIDTH-1:0] d);
        @(negedge clk);
        push    = p;
        pop     = o;
        tos     = t;
        err_clr = c;
        d_in    = d;
        @(posedge clk);
        model_step(p, o, t, c, d);
        #1;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("d_out", 32'(d_out), 32'(m_dout));
            chk("d_valid", 32'(d_valid), 32'(m_valid));
            chk("count", 32'(count), 32'(stk.size()));
            chk("full", 32'(full), 32'(stk.size() == DEPTH));
            chk("empty", 32'(empty), 32'(stk.size() == 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
        end
    end

    initial begin
        model_reset();
        #22 rst_n = 1'b1;

        // Reset then idle.
        repeat (3) step(0, 0, 0, 0, 8'h00);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_dout", 32'(d_out), 0);
        chk("rst_flags", {30'd0, overflow, underflow}, 0);

        // Basic LIFO order with a tos peek.
        step(1, 0, 0, 0, 8'h11);
        step(1, 0, 0, 0, 8'h22);
        step(1, 0, 0, 0, 8'h33);
        step(0, 0, 1, 0, 8'h00);
        chk("tos_dout", 32'(d_out), 32'h33);
        chk("tos_count", 32'(count), 3);
        step(0, 1, 0, 0, 8'h00);
        chk("pop1", {23'd0, d_valid, d_out}, 32'h133);
        step(0, 1, 0, 0, 8'h00);
        chk("pop2", {23'd0, d_valid, d_out}, 32'h122);
        step(0, 1, 0, 0, 8'h00);
        chk("pop3", {23'd0, d_valid, d_out}, 32'h111);
        chk("pop_empty", {30'd0, empty, 1'b0} | 32'(count), 2);

        // Fill, overflow, clear.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'hA0 + 8'(i));
        chk("full", 32'(full), 1);
        step(1, 0, 0, 0, 8'hFF);
        chk("ovf", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 4);
        step(0, 1, 0, 0, 8'h00);
        chk("ovf_pop", 32'(d_out), 32'hA3);
        step(0, 0, 0, 1, 8'h00);
        chk("ovf_clr", 32'(overflow), 0);
        repeat (3) step(0, 1, 0, 0, 8'h00);

        // Replace.
        step(1, 0, 0, 0, 8'h05);
        step(1, 1, 0, 0, 8'h06);
        chk("repl_dout", 32'(d_out), 32'h05);
        chk("repl_count", 32'(count), 1);
        step(0, 1, 0, 0, 8'h00);
        chk("repl_pop", 32'(d_out), 32'h06);

        // Underflow from empty.
        step(0, 1, 0, 0, 8'h00);
        chk("unf_pop", {22'd0, underflow, d_valid, d_out}, 32'h206);
        step(0, 0, 1, 0, 8'h00);
        chk("unf_tos", {22'd0, underflow, d_valid, d_out}, 32'h206);
        step(1, 1, 0, 0, 8'h77);
        chk("unf_repl_count", 32'(count), 1);
        chk("unf_repl_flag", 32'(underflow), 1);
        step(0, 1, 0, 1, 8'h00);
        chk("unf_clr", 32'(underflow), 0);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'h40 + 8'(i));
        step(0, 0, 1, 0, 8'h00);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_dout", 32'(d_out), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(0, 1, 0, 0, 8'h00);
        chk("arst_unf", 32'(underflow), 1);
        step(0, 0, 0, 1, 8'h00);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic p, o, t, c;
            p = ($urandom_range(99) < 45);
            o = ($urandom_range(99) < 40);
            t = ($urandom_range(99) < 25);
            c = ($urandom_range(99) < 8);
            step(p, o, t, c, 8'($urandom));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
